// File: rtl/parity_sweep_ctrl.sv
// parity_sweep_ctrl: exhaustive sweep of a parity unit against a golden masked parity, with error count and first-fail capture
module parity_sweep_ctrl #(
    parameter int              WIDTH  = 9,
    parameter logic [WIDTH-1:0] MASK  = 9'h1EF,
    parameter int              SETTLE = 1,
    parameter int              ERR_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] dut_a,
    input  logic             dut_parity,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] first_fail,
    output logic             first_fail_valid
);
    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] vec_q, vec_d, ff_q, ff_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ffv_q, ffv_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic             mismatch;
    // case-inequality so X/Z from the unit under test counts as a failure
    assign mismatch = dut_parity !== ^(vec_q & MASK);
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = WAIT;
                vec_d   = '0;
                cnt_d   = '0;
                err_d   = '0;
                ff_d    = '0;
                ffv_d   = 1'b0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
            WAIT: begin
                state_d = (cnt_q == 4'(SETTLE - 1)) ? CHECK : WAIT;
                cnt_d   = (cnt_q == 4'(SETTLE - 1)) ? '0 : cnt_q + 4'd1;
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = (err_q == '1) ? err_q : err_q + 1'b1;
                    ff_d  = ffv_q ? ff_q : vec_q;
                    ffv_d = 1'b1;
                end
                if (vec_q == '1) begin
                    state_d = DONE;
                    vec_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = WAIT;
                    vec_d   = vec_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // abort overrides start and any transition, but keeps the results for debug
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            vec_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end
    assign dut_a            = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail       = ff_q;
    assign first_fail_valid = ffv_q;
endmodule

// File: tb/tb_parity_sweep_ctrl.sv
// tb_parity_sweep_ctrl: directed checks of the sweep controller against several parity-unit models
module tb_parity_sweep_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start_x = 1'b0;
    logic abort = 1'b0;
    logic [1:0] mode = 2'd0;
    int checks = 0;
    int errors = 0;
    logic [8:0] a0, a1, a2, a3, ff0, ff1, ff2, ff3;
    logic [9:0] err0, err2, err3;
    logic [3:0] err1;
    logic p0, busy0, done0, pass0, ffv0;
    logic busy1, done1, pass1, ffv1;
    logic busy2, done2, pass2, ffv2;
    logic busy3, done3, pass3, ffv3;
    logic p2a = 1'b0, p2b = 1'b0, p3a = 1'b0, p3b = 1'b0;
    always #5 clk = ~clk;
    // mode 0: golden, 1: full 9-bit xor, 2: stuck at 0
    assign p0 = (mode == 2'd0) ? ^(a0 & 9'h1EF) : (mode == 2'd1) ? ^a0 : 1'b0;
    // two-cycle-latency golden units
    always @(posedge clk) begin
        p2a <= ^(a2 & 9'h1EF);
        p2b <= p2a;
        p3a <= ^(a3 & 9'h1EF);
        p3b <= p3a;
    end
    parity_sweep_ctrl u0 (.clk(clk), .rst(rst), .start(start), .abort(abort), .dut_a(a0),
        .dut_parity(p0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail(ff0), .first_fail_valid(ffv0));
    parity_sweep_ctrl #(.ERR_W(4)) u1 (.clk(clk), .rst(rst), .start(start_x), .abort(abort),
        .dut_a(a1), .dut_parity(1'b0), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(ff1), .first_fail_valid(ffv1));
    parity_sweep_ctrl #(.SETTLE(3)) u2 (.clk(clk), .rst(rst), .start(start_x), .abort(abort),
        .dut_a(a2), .dut_parity(p2b), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_fail(ff2), .first_fail_valid(ffv2));
    parity_sweep_ctrl u3 (.clk(clk), .rst(rst), .start(start_x), .abort(abort), .dut_a(a3),
        .dut_parity(p3b), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_fail(ff3), .first_fail_valid(ffv3));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic pulse(input logic main, input logic extra);
        @(negedge clk);
        start = main;
        start_x = extra;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_x = 1'b0;
    endtask
    task automatic wait_vec(input logic [8:0] v);
        int n = 0;
        while (a0 != v && n < 3000) begin
            tick(1);
            n++;
        end
        check("reach_vec", a0, v);
    endtask
    task automatic check_idle_zero(input string tag);
        check({tag, "_dut_a"}, a0, 0);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_done"}, done0, 0);
        check({tag, "_pass"}, pass0, 0);
        check({tag, "_err"}, err0, 0);
        check({tag, "_ff"}, ff0, 0);
        check({tag, "_ffv"}, ffv0, 0);
    endtask
    task automatic run_to_done;
        tick(1023);
        check("pre_done", done0, 0);
        tick(1);
        check("done", done0, 1);
        check("done_busy", busy0, 0);
        check("done_dut_a", a0, 0);
    endtask
    initial begin
        int bad, early, exp_err;
        logic [8:0] vv;
        tick(2);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        check_idle_zero("reset");
        // golden sweep with vector ordering and done latency
        mode = 2'd0;
        pulse(1'b1, 1'b0);
        bad = 0;
        early = 0;
        for (int k = 0; k < 1024; k++) begin
            if (a0 != 9'(k / 2)) bad++;
            if (done0 || !busy0) early++;
            tick(1);
        end
        check("sweep_order", bad, 0);
        check("sweep_busy", early, 0);
        check("gold_done", done0, 1);
        check("gold_pass", pass0, 1);
        check("gold_err", err0, 0);
        check("gold_ffv", ffv0, 0);
        // restart from DONE with bit 4 wrongly included
        mode = 2'd1;
        pulse(1'b1, 1'b0);
        check("restart_done_clr", done0, 0);
        check("restart_busy", busy0, 1);
        run_to_done;
        check("xor_err", err0, 256);
        check("xor_ff", ff0, 9'h010);
        check("xor_ffv", ffv0, 1);
        check("xor_pass", pass0, 0);
        // stuck-at-0 on u0 and the auxiliary instances in parallel
        mode = 2'd2;
        pulse(1'b1, 1'b1);
        run_to_done;
        check("stuck_err", err0, 256);
        check("stuck_ff", ff0, 9'h001);
        check("stuck_ffv", ffv0, 1);
        check("stuck_pass", pass0, 0);
        check("sat_done", done1, 1);
        check("sat_err", err1, 15);
        check("sat_ff", ff1, 9'h001);
        check("lat1_done", done3, 1);
        check("lat1_pass", pass3, 0);
        check("lat1_err_nz", err3 != 0, 1);
        check("lat3_busy", busy2, 1);
        tick(1023);
        check("lat3_pre_done", done2, 0);
        tick(1);
        check("lat3_done", done2, 1);
        check("lat3_pass", pass2, 1);
        check("lat3_err", err2, 0);
        // abort at vector 100 keeps results
        exp_err = 0;
        for (int v = 0; v < 100; v++) begin
            vv = 9'(v);
            exp_err += int'(^(vv & 9'h1EF));
        end
        pulse(1'b1, 1'b0);
        wait_vec(9'd100);
        @(negedge clk);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy", busy0, 0);
        check("abort_done", done0, 0);
        check("abort_pass", pass0, 0);
        check("abort_dut_a", a0, 0);
        check("abort_err", err0, exp_err);
        check("abort_ff", ff0, 9'h001);
        check("abort_ffv", ffv0, 1);
        tick(3);
        check("abort_idle", busy0, 0);
        // golden sweep with an ignored start while busy
        mode = 2'd0;
        pulse(1'b1, 1'b0);
        check("fresh_err_clr", err0, 0);
        check("fresh_ffv_clr", ffv0, 0);
        tick(199);
        pulse(1'b1, 1'b0);
        check("ignored_start_busy", busy0, 1);
        tick(823);
        check("ignored_pre_done", done0, 0);
        tick(1);
        check("ignored_done", done0, 1);
        check("ignored_pass", pass0, 1);
        check("ignored_err", err0, 0);
        // abort and start together from DONE
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        tick(1);
        abort = 1'b0;
        start = 1'b0;
        check("both_busy", busy0, 0);
        check("both_done", done0, 0);
        tick(2);
        check("both_not_latched", busy0, 0);
        // reset mid-sweep at vector 300
        mode = 2'd2;
        pulse(1'b1, 1'b0);
        wait_vec(9'd300);
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        check_idle_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 1100; k++) begin
            tick(1);
            if (busy0 || done0) bad++;
        end
        check("midrst_quiet", bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
